// File: rtl/alu_operand_seq.sv
// Operand sequencer and result capture around an external 8-bit 74181-style ALU.
// Loads two operands from the shared data bus, lets the ALU settle for one cycle,
// captures F/CO/FZ into RES and the flags, then presents RES with a DONE pulse.
//
// Operand handshake: D_VALID is a one-sided valid; there is no ready back to the
// source. An operand is taken on any rising edge where D_VALID=1 and the FSM is
// in LDA (first operand) or LDB (second operand). D_VALID in any other state is
// ignored, so the source must keep presenting the operand until the FSM reaches
// the matching load state.
module alu_operand_seq #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [3:0]       S_IN,
   input  logic             M_IN,
   input  logic             CN_IN,
   input  logic             CSEL,
   input  logic [WIDTH-1:0] D_IN,
   input  logic             D_VALID,
   output logic [WIDTH-1:0] A_OUT,
   output logic [WIDTH-1:0] B_OUT,
   output logic [3:0]       S_OUT,
   output logic             M_OUT,
   output logic             CN_OUT,
   input  logic [WIDTH-1:0] F_IN,
   input  logic             CO_IN,
   input  logic             FZ_IN,
   output logic [WIDTH-1:0] D_OUT,
   output logic             D_OE,
   output logic             DONE,
   output logic             BUSY,
   output logic             CY_FLAG,
   output logic             Z_FLAG,
   output logic             EQ_FLAG
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDA  = 3'd1,
      LDB  = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   dr1_q, dr1_d;
   logic [WIDTH-1:0]   dr2_q, dr2_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [3:0]         s_q, s_d;
   logic               m_q, m_d;
   logic               cn_q, cn_d;
   logic               csel_q, csel_d;
   logic               cy_q, cy_d;
   logic               z_q, z_d;
   logic               eq_q, eq_d;

   // Next-state and datapath load decisions; everything holds by default.
   always_comb begin
      state_d = state_q;
      dr1_d   = dr1_q;
      dr2_d   = dr2_q;
      res_d   = res_q;
      s_d     = s_q;
      m_d     = m_q;
      cn_d    = cn_q;
      csel_d  = csel_q;
      cy_d    = cy_q;
      z_d     = z_q;
      eq_d    = eq_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               s_d     = S_IN;
               m_d     = M_IN;
               cn_d    = CN_IN;
               csel_d  = CSEL;
               state_d = LDA;
            end
         end
         LDA: begin
            if (D_VALID) begin
               dr1_d   = D_IN;
               state_d = LDB;
            end
         end
         LDB: begin
            if (D_VALID) begin
               dr2_d   = D_IN;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // The ALU has had a full cycle on registered inputs; take {CO,F} as is.
            res_d   = F_IN;
            cy_d    = CO_IN;
            eq_d    = ~FZ_IN;
            z_d     = (F_IN == '0);
            state_d = WB;
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         dr1_q   <= '0;
         dr2_q   <= '0;
         res_q   <= '0;
         s_q     <= '0;
         m_q     <= 1'b0;
         cn_q    <= 1'b0;
         csel_q  <= 1'b0;
         cy_q    <= 1'b0;
         z_q     <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dr1_q   <= dr1_d;
         dr2_q   <= dr2_d;
         res_q   <= res_d;
         s_q     <= s_d;
         m_q     <= m_d;
         cn_q    <= cn_d;
         csel_q  <= csel_d;
         cy_q    <= cy_d;
         z_q     <= z_d;
         eq_q    <= eq_d;
      end
   end

   // Stored carry only changes at the end of EXEC, so muxing it live gives the
   // value held when START was accepted for the whole time the ALU uses it.
   assign CN_OUT  = csel_q ? cy_q : cn_q;
   assign A_OUT   = dr1_q;
   assign B_OUT   = dr2_q;
   assign S_OUT   = s_q;
   assign M_OUT   = m_q;
   assign D_OUT   = res_q;
   assign DONE    = (state_q == WB);
   assign D_OE    = (state_q == WB);
   assign BUSY    = (state_q != IDLE);
   assign CY_FLAG = cy_q;
   assign Z_FLAG  = z_q;
   assign EQ_FLAG = eq_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a small behavioural ALU in the loop.
module tb_alu_operand_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] s_in;
   logic       m_in;
   logic       cn_in;
   logic       csel;
   logic [7:0] d_in;
   logic       d_valid;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic [3:0] s_out;
   logic       m_out;
   logic       cn_out;
   logic [7:0] f_in;
   logic       co_in;
   logic       fz_in;
   logic [7:0] d_out;
   logic       d_oe;
   logic       done;
   logic       busy;
   logic       cy_flag;
   logic       z_flag;
   logic       eq_flag;

   int total = 0;
   int bad   = 0;

   alu_operand_seq #(.WIDTH(8)) dut (
      .CLK(clk), .RST(rst), .START(start), .S_IN(s_in), .M_IN(m_in),
      .CN_IN(cn_in), .CSEL(csel), .D_IN(d_in), .D_VALID(d_valid),
      .A_OUT(a_out), .B_OUT(b_out), .S_OUT(s_out), .M_OUT(m_out),
      .CN_OUT(cn_out), .F_IN(f_in), .CO_IN(co_in), .FZ_IN(fz_in),
      .D_OUT(d_out), .D_OE(d_oe), .DONE(done), .BUSY(busy),
      .CY_FLAG(cy_flag), .Z_FLAG(z_flag), .EQ_FLAG(eq_flag)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: add (1001/M=0), subtract with borrow out (0110/M=0), xor (0110/M=1).
   always_comb begin
      logic [8:0] r;
      r = 9'd0;
      if (!m_out && s_out == 4'b1001)
         r = {1'b0, a_out} + {1'b0, b_out} + {8'd0, cn_out};
      else if (!m_out && s_out == 4'b0110)
         r = {1'b0, a_out} - {1'b0, b_out} - {8'd0, cn_out};
      else if (m_out && s_out == 4'b0110)
         r = {1'b0, a_out ^ b_out};
      f_in  = r[7:0];
      co_in = r[8];
      fz_in = (a_out != b_out);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation, driven and sampled on negative edges. abort stops in EXEC.
   task automatic run_op(input string tag, input logic [3:0] s, input logic m,
                         input logic cn, input logic cs, input logic [7:0] a,
                         input logic [7:0] b, input int stall, input bit pulse,
                         input logic exp_cn, input bit abort);
      @(negedge clk);
      start = 1'b1; s_in = s; m_in = m; cn_in = cn; csel = cs; d_valid = 1'b0;
      @(negedge clk);                       // LDA
      start = 1'b0;
      chk({tag, ".busy_lda"}, busy, 1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, ".stall_a_busy"}, busy, 1);
         chk({tag, ".stall_a_done"}, done, 0);
      end
      d_valid = 1'b1; d_in = a;
      @(negedge clk);                       // LDB
      d_valid = 1'b0;
      chk({tag, ".a_out"}, a_out, a);
      start = pulse;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, ".stall_b_done"}, done, 0);
         chk({tag, ".stall_b_oe"}, d_oe, 0);
      end
      d_valid = 1'b1; d_in = b;
      @(negedge clk);                       // EXEC
      d_valid = 1'b0; start = 1'b0;
      chk({tag, ".b_out"}, b_out, b);
      chk({tag, ".s_out"}, s_out, s);
      chk({tag, ".m_out"}, m_out, m);
      chk({tag, ".cn_out"}, cn_out, exp_cn);
      chk({tag, ".done_exec"}, done, 0);
      chk({tag, ".oe_exec"}, d_oe, 0);
      if (!abort) begin
         @(negedge clk);                    // WB
         start = pulse;
         chk({tag, ".done_wb"}, done, 1);
         chk({tag, ".oe_wb"}, d_oe, 1);
         chk({tag, ".busy_wb"}, busy, 1);
         @(negedge clk);                    // IDLE
         start = 1'b0;
         chk({tag, ".done_idle"}, done, 0);
         chk({tag, ".oe_idle"}, d_oe, 0);
         chk({tag, ".busy_idle"}, busy, 0);
         @(negedge clk);                    // still IDLE: WB start not taken
         chk({tag, ".busy_idle2"}, busy, 0);
         chk({tag, ".done_idle2"}, done, 0);
      end
   endtask

   task automatic chk_res(input string tag, input logic [7:0] res, input logic cy,
                          input logic z, input logic eq);
      chk({tag, ".d_out"}, d_out, res);
      chk({tag, ".cy"}, cy_flag, cy);
      chk({tag, ".z"}, z_flag, z);
      chk({tag, ".eq"}, eq_flag, eq);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".oe"}, d_oe, 0);
      chk({tag, ".d_out"}, d_out, 0);
      chk({tag, ".cy"}, cy_flag, 0);
      chk({tag, ".z"}, z_flag, 0);
      chk({tag, ".eq"}, eq_flag, 0);
      chk({tag, ".a"}, a_out, 0);
      chk({tag, ".b"}, b_out, 0);
      chk({tag, ".s"}, s_out, 0);
      chk({tag, ".m"}, m_out, 0);
      chk({tag, ".cn"}, cn_out, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_in = 4'h0; m_in = 1'b0; cn_in = 1'b0;
      csel = 1'b0; d_in = 8'h00; d_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // 3C + 05 = 41
      run_op("add", 4'b1001, 0, 0, 0, 8'h3C, 8'h05, 0, 0, 0, 0);
      chk_res("add", 8'h41, 0, 0, 0);

      // FF + 01 = 100, then stored carry into 00 + 00
      run_op("chain1", 4'b1001, 0, 0, 0, 8'hFF, 8'h01, 0, 0, 0, 0);
      chk_res("chain1", 8'h00, 1, 1, 0);
      run_op("chain2", 4'b1001, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0);
      chk_res("chain2", 8'h01, 0, 0, 1);

      // 05 - 05 = 00; 03 - 05 = FE with borrow
      run_op("sub_eq", 4'b0110, 0, 0, 0, 8'h05, 8'h05, 0, 0, 0, 0);
      chk_res("sub_eq", 8'h00, 0, 1, 1);
      run_op("sub_bw", 4'b0110, 0, 0, 0, 8'h03, 8'h05, 0, 0, 0, 0);
      chk_res("sub_bw", 8'hFE, 1, 0, 0);

      // Reset in EXEC abandons the op and clears everything
      run_op("abort", 4'b1001, 0, 1, 0, 8'h11, 8'h22, 0, 0, 1, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst_exec");
      @(negedge clk);
      chk({"rst_exec", ".no_done"}, done, 0);

      // Normal add after reset: 10 + 20 = 30
      run_op("post_rst", 4'b1001, 0, 0, 0, 8'h10, 8'h20, 0, 0, 0, 0);
      chk_res("post_rst", 8'h30, 0, 0, 0);

      // Logic XOR with three-cycle stalls on both loads: F0 ^ FF = 0F
      run_op("xor_stall", 4'b0110, 1, 0, 0, 8'hF0, 8'hFF, 3, 0, 0, 0);
      chk_res("xor_stall", 8'h0F, 0, 0, 0);

      // START pulsed in LDB and WB is ignored: 01 + 02 = 03
      run_op("start_ign", 4'b1001, 0, 0, 0, 8'h01, 8'h02, 0, 1, 0, 0);
      chk_res("start_ign", 8'h03, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
